// File: rtl/uart_rx_frame_param.sv
// Parametrised UART receiver: synchronised, majority-voted rx sampling with
// parity/framing checks and a valid/ready holding register that flags overruns.
module uart_rx_frame_param #(
    parameter int DATA_BITS   = 7,
    parameter int OVERSAMPLE  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 overrun_err,
    output logic [2:0]           state_out,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] VOTE_PT   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_PT   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             sync_reg;
    logic [2:0]             vote_sh_reg;
    logic [CNT_W-1:0]       sample_cnt_reg, sample_cnt_next;
    logic [3:0]             bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   parity_err_reg, parity_err_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   frame_done;
    logic                   rxs;
    logic                   vote;
    logic [DATA_BITS:0]     par_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rxs = sync_reg[1];

    // The register holds the three most recent tick samples; at the vote
    // point these are the samples captured entering counts VOTE_PT-2..VOTE_PT.
    assign vote = (vote_sh_reg[0] & vote_sh_reg[1]) |
                  (vote_sh_reg[0] & vote_sh_reg[2]) |
                  (vote_sh_reg[1] & vote_sh_reg[2]);

    assign par_chain[0] = 1'b0;
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_par
        assign par_chain[gi+1] = par_chain[gi] ^ shift_reg[gi];
    end

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_err_next = parity_err_reg;
        frame_err_next  = frame_err_reg;
        frame_done      = 1'b0;
        if (ena) begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    sample_cnt_next = '0;
                    if (!rxs) begin
                        state_next      = START;
                        parity_err_next = 1'b0;
                        frame_err_next  = 1'b0;
                    end
                end
                START: begin
                    if (sample_cnt_reg == VOTE_PT && vote) begin
                        state_next      = IDLE;
                        sample_cnt_next = '0;
                    end else if (sample_cnt_reg == LAST_PT) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    if (sample_cnt_reg == VOTE_PT) begin
                        shift_next   = {vote, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                    if (sample_cnt_reg == LAST_PT && bit_cnt_reg == DATA_LAST) begin
                        state_next   = (PARITY_MODE != 0) ? PARITY : STOP;
                        bit_cnt_next = '0;
                    end
                end
                PARITY: begin
                    if (sample_cnt_reg == VOTE_PT) begin
                        parity_err_next = ((par_chain[DATA_BITS] ^ vote) != ODD_PAR);
                    end
                    if (sample_cnt_reg == LAST_PT) begin
                        state_next   = STOP;
                        bit_cnt_next = '0;
                    end
                end
                STOP: begin
                    // Finish at the last stop-bit vote so a following start
                    // edge half a bit later is still seen from IDLE.
                    if (sample_cnt_reg == VOTE_PT) begin
                        frame_err_next = frame_err_reg | ~vote;
                        if (bit_cnt_reg == STOP_LAST) begin
                            frame_done      = 1'b1;
                            state_next      = IDLE;
                            sample_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next      = IDLE;
                    sample_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            vote_sh_reg    <= 3'b111;
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            if (ena) begin
                vote_sh_reg <= {vote_sh_reg[1:0], rxs};
            end
        end
    end

    // Holding register: a completed frame is only dropped when the previous
    // word is still unaccepted in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_parity_err <= 1'b0;
            out_frame_err  <= 1'b0;
            overrun_err    <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!out_valid || out_ready) begin
                    out_data       <= shift_reg;
                    out_parity_err <= parity_err_reg;
                    out_frame_err  <= frame_err_next;
                    out_valid      <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign state_out = state_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_param.sv
// Directed bench for uart_rx_frame_param: three instances cover the default
// framing, 8-bit even parity and two stop bits.
module tb_uart_rx_frame_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [2:0] rx_vec = 3'b111;
    logic [2:0] rdy = 3'b111;

    logic [6:0] d0;
    logic [7:0] d1;
    logic [6:0] d2;
    logic [2:0] v, pe, fe, ovr, bsy;
    logic [2:0] st0, st1, st2;

    int n_cmp = 0;
    int n_err = 0;

    int         xfer [3] = '{0, 0, 0};
    int         ovr_cnt [3] = '{0, 0, 0};
    logic [7:0] last_d [3] = '{8'h00, 8'h00, 8'h00};
    logic       last_pe [3] = '{1'b0, 1'b0, 1'b0};
    logic       last_fe [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    uart_rx_frame_param u_dut0 (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx_vec[0]),
        .out_data(d0), .out_valid(v[0]), .out_ready(rdy[0]),
        .out_parity_err(pe[0]), .out_frame_err(fe[0]), .overrun_err(ovr[0]),
        .state_out(st0), .busy(bsy[0])
    );

    uart_rx_frame_param #(.DATA_BITS(8), .PARITY_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx_vec[1]),
        .out_data(d1), .out_valid(v[1]), .out_ready(rdy[1]),
        .out_parity_err(pe[1]), .out_frame_err(fe[1]), .overrun_err(ovr[1]),
        .state_out(st1), .busy(bsy[1])
    );

    uart_rx_frame_param #(.STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx_vec[2]),
        .out_data(d2), .out_valid(v[2]), .out_ready(rdy[2]),
        .out_parity_err(pe[2]), .out_frame_err(fe[2]), .overrun_err(ovr[2]),
        .state_out(st2), .busy(bsy[2])
    );

    // Record every accepted word and every overrun pulse.
    always @(posedge clk) begin
        if (!rst) begin
            if (v[0] && rdy[0]) begin
                xfer[0]++; last_d[0] = {1'b0, d0}; last_pe[0] = pe[0]; last_fe[0] = fe[0];
            end
            if (v[1] && rdy[1]) begin
                xfer[1]++; last_d[1] = d1; last_pe[1] = pe[1]; last_fe[1] = fe[1];
            end
            if (v[2] && rdy[2]) begin
                xfer[2]++; last_d[2] = {1'b0, d2}; last_pe[2] = pe[2]; last_fe[2] = fe[2];
            end
            for (int i = 0; i < 3; i++) begin
                if (ovr[i]) ovr_cnt[i]++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // bits[0] is sent first; each bit lasts 8 oversample ticks.
    task automatic send_frame(input int which, input int nbits, input logic [15:0] bits);
        for (int i = 0; i < nbits; i++) begin
            rx_vec[which] = bits[i];
            tick(8);
        end
        rx_vec[which] = 1'b1;
    endtask

    task automatic test_reset;
        tick(2);
        n_cmp++; if (d0 !== 7'h00) begin n_err++; $display("FAIL reset_data: got %h want %h", d0, 7'h00); end
        n_cmp++; if (v !== 3'b000) begin n_err++; $display("FAIL reset_valid: got %b want %b", v, 3'b000); end
        n_cmp++; if (pe[0] !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", pe[0]); end
        n_cmp++; if (fe[0] !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", fe[0]); end
        n_cmp++; if (ovr[0] !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", ovr[0]); end
        n_cmp++; if (st0 !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", st0); end
        n_cmp++; if (bsy !== 3'b000) begin n_err++; $display("FAIL reset_busy: got %b want %b", bsy, 3'b000); end
        rst = 1'b0;
        tick(4);
        n_cmp++; if (st0 !== 3'd0) begin n_err++; $display("FAIL idle_state: got %0d want 0", st0); end
        n_cmp++; if (v !== 3'b000) begin n_err++; $display("FAIL idle_valid: got %b want %b", v, 3'b000); end
    endtask

    task automatic test_basic_frame;
        int x0;
        x0 = xfer[0];
        send_frame(0, 9, {7'd0, 1'b1, 7'h55, 1'b0});
        tick(6);
        n_cmp++; if (xfer[0] - x0 !== 1) begin n_err++; $display("FAIL basic_count: got %0d want 1", xfer[0] - x0); end
        n_cmp++; if (last_d[0] !== 8'h55) begin n_err++; $display("FAIL basic_data: got %h want %h", last_d[0], 8'h55); end
        n_cmp++; if (last_pe[0] !== 1'b0) begin n_err++; $display("FAIL basic_perr: got %b want 0", last_pe[0]); end
        n_cmp++; if (last_fe[0] !== 1'b0) begin n_err++; $display("FAIL basic_ferr: got %b want 0", last_fe[0]); end
        n_cmp++; if (st0 !== 3'd0) begin n_err++; $display("FAIL basic_state: got %0d want 0", st0); end
        n_cmp++; if (v[0] !== 1'b0) begin n_err++; $display("FAIL basic_valid_clear: got %b want 0", v[0]); end
    endtask

    task automatic test_false_start;
        int  x0;
        logic saw;
        x0  = xfer[0];
        saw = 1'b0;
        rx_vec[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (st0 == 3'd1) saw = 1'b1;
        end
        rx_vec[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (st0 == 3'd1) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b1) begin n_err++; $display("FAIL fstart_entered: got %b want 1", saw); end
        n_cmp++; if (st0 !== 3'd0) begin n_err++; $display("FAIL fstart_state: got %0d want 0", st0); end
        n_cmp++; if (xfer[0] - x0 !== 0) begin n_err++; $display("FAIL fstart_count: got %0d want 0", xfer[0] - x0); end
        n_cmp++; if (v[0] !== 1'b0) begin n_err++; $display("FAIL fstart_valid: got %b want 0", v[0]); end
        tick(8);
    endtask

    task automatic test_parity;
        int x1;
        x1 = xfer[1];
        send_frame(1, 11, {5'd0, 1'b1, 1'b1, 8'hA3, 1'b0});
        tick(6);
        n_cmp++; if (xfer[1] - x1 !== 1) begin n_err++; $display("FAIL par1_count: got %0d want 1", xfer[1] - x1); end
        n_cmp++; if (last_d[1] !== 8'hA3) begin n_err++; $display("FAIL par1_data: got %h want %h", last_d[1], 8'hA3); end
        n_cmp++; if (last_pe[1] !== 1'b1) begin n_err++; $display("FAIL par1_perr: got %b want 1", last_pe[1]); end
        n_cmp++; if (last_fe[1] !== 1'b0) begin n_err++; $display("FAIL par1_ferr: got %b want 0", last_fe[1]); end
        send_frame(1, 11, {5'd0, 1'b1, 1'b0, 8'hA3, 1'b0});
        tick(6);
        n_cmp++; if (xfer[1] - x1 !== 2) begin n_err++; $display("FAIL par0_count: got %0d want 2", xfer[1] - x1); end
        n_cmp++; if (last_d[1] !== 8'hA3) begin n_err++; $display("FAIL par0_data: got %h want %h", last_d[1], 8'hA3); end
        n_cmp++; if (last_pe[1] !== 1'b0) begin n_err++; $display("FAIL par0_perr: got %b want 0", last_pe[1]); end
    endtask

    task automatic test_frame_err;
        int x2;
        x2 = xfer[2];
        send_frame(2, 10, {6'd0, 1'b0, 1'b1, 7'h2A, 1'b0});
        tick(16);
        n_cmp++; if (xfer[2] - x2 !== 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", xfer[2] - x2); end
        n_cmp++; if (last_d[2] !== 8'h2A) begin n_err++; $display("FAIL ferr_data: got %h want %h", last_d[2], 8'h2A); end
        n_cmp++; if (last_fe[2] !== 1'b1) begin n_err++; $display("FAIL ferr_flag: got %b want 1", last_fe[2]); end
        n_cmp++; if (last_pe[2] !== 1'b0) begin n_err++; $display("FAIL ferr_perr: got %b want 0", last_pe[2]); end
        n_cmp++; if (st2 !== 3'd0) begin n_err++; $display("FAIL ferr_state: got %0d want 0", st2); end
        send_frame(2, 10, {6'd0, 1'b1, 1'b1, 7'h2A, 1'b0});
        tick(6);
        n_cmp++; if (xfer[2] - x2 !== 2) begin n_err++; $display("FAIL fok_count: got %0d want 2", xfer[2] - x2); end
        n_cmp++; if (last_fe[2] !== 1'b0) begin n_err++; $display("FAIL fok_flag: got %b want 0", last_fe[2]); end
    endtask

    task automatic test_back_to_back;
        int x0, o0;
        x0 = xfer[0];
        o0 = ovr_cnt[0];
        rdy[0] = 1'b0;
        send_frame(0, 9, {7'd0, 1'b1, 7'h12, 1'b0});
        send_frame(0, 9, {7'd0, 1'b1, 7'h34, 1'b0});
        tick(6);
        n_cmp++; if (v[0] !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b want 1", v[0]); end
        n_cmp++; if (d0 !== 7'h12) begin n_err++; $display("FAIL b2b_held_data: got %h want %h", d0, 7'h12); end
        n_cmp++; if (ovr_cnt[0] - o0 !== 1) begin n_err++; $display("FAIL b2b_overrun: got %0d want 1", ovr_cnt[0] - o0); end
        n_cmp++; if (xfer[0] - x0 !== 0) begin n_err++; $display("FAIL b2b_no_xfer: got %0d want 0", xfer[0] - x0); end
        rdy[0] = 1'b1;
        tick(1);
        n_cmp++; if (v[0] !== 1'b0) begin n_err++; $display("FAIL b2b_valid_clear: got %b want 0", v[0]); end
        n_cmp++; if (last_d[0] !== 8'h12) begin n_err++; $display("FAIL b2b_xfer_data: got %h want %h", last_d[0], 8'h12); end
        n_cmp++; if (xfer[0] - x0 !== 1) begin n_err++; $display("FAIL b2b_xfer_count: got %0d want 1", xfer[0] - x0); end
        tick(4);
    endtask

    task automatic test_reset_mid_frame;
        int x0;
        rdy[0] = 1'b0;
        send_frame(0, 9, {7'd0, 1'b1, 7'h2B, 1'b0});
        tick(6);
        n_cmp++; if (d0 !== 7'h2B) begin n_err++; $display("FAIL rmid_held: got %h want %h", d0, 7'h2B); end
        send_frame(0, 4, {7'd0, 1'b1, 7'h7F, 1'b0});
        n_cmp++; if (st0 !== 3'd2) begin n_err++; $display("FAIL rmid_in_data: got %0d want 2", st0); end
        rst = 1'b1;
        #1;
        n_cmp++; if (st0 !== 3'd0) begin n_err++; $display("FAIL rmid_state: got %0d want 0", st0); end
        n_cmp++; if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", bsy[0]); end
        n_cmp++; if (v[0] !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", v[0]); end
        n_cmp++; if (d0 !== 7'h00) begin n_err++; $display("FAIL rmid_data: got %h want %h", d0, 7'h00); end
        tick(2);
        rst = 1'b0;
        tick(4);
        rdy[0] = 1'b1;
        x0 = xfer[0];
        send_frame(0, 9, {7'd0, 1'b1, 7'h01, 1'b0});
        tick(6);
        n_cmp++; if (xfer[0] - x0 !== 1) begin n_err++; $display("FAIL rpost_count: got %0d want 1", xfer[0] - x0); end
        n_cmp++; if (last_d[0] !== 8'h01) begin n_err++; $display("FAIL rpost_data: got %h want %h", last_d[0], 8'h01); end
        n_cmp++; if (last_fe[0] !== 1'b0) begin n_err++; $display("FAIL rpost_ferr: got %b want 0", last_fe[0]); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_false_start();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_param.md
Name: uart_rx_frame_param

Overview:
- Parametrised UART receiver: next generation of the project's fixed 7-bit Hamming receive path.
- Configurable in:
  - data width
  - oversampling ratio
  - parity mode
  - stop-bit count
- Adds to the previous generation:
  - input synchroniser
  - 3-sample majority vote
  - parity and framing error flags
  - valid/ready output holding register with overrun detection
- Sits between the rx pin and the Hamming decoder, which consumes out_data when out_valid && out_ready.

Parameters:
DATA_BITS, 7, data bits per frame, LSB first; legal 5..9.
OVERSAMPLE, 8, ena ticks per bit period; power of two, legal 8..16.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits checked per frame; legal 1..2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ena  in  1  oversample tick; all counters and the FSM advance only on clk edges with ena=1
rx  in  1  serial line, idle high, asynchronous to clk
out_data  out  DATA_BITS  received word
out_valid  out  1  out_data and the error flags are valid
out_ready  in  1  consumer accepts the word
out_parity_err  out  1  parity mismatch on the held word (0 when PARITY_MODE=0)
out_frame_err  out  1  any stop-bit vote was 0 on the held word
overrun_err  out  1  one-cycle pulse: a completed frame was dropped
state_out  out  3  FSM state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; counters to 0.
  - Two-flop rx synchroniser to 1; vote shift register to 3'b111.
  - out_data = 0; out_valid, out_parity_err, out_frame_err, overrun_err, busy = 0; state_out = 0.
  - Reset mid-frame discards the partial frame and any held word.
- Sampling:
  - rxs is the output of the 2-flop synchroniser; it feeds a 3-bit shift register clocked on ena ticks.
  - vote = majority of the last 3 rxs samples.
  - Vote point is the tick where sample_cnt == OVERSAMPLE/2+1 (samples at OVERSAMPLE/2-1 .. OVERSAMPLE/2+1).
  - sample_cnt is log2(OVERSAMPLE) bits wide; it wraps from OVERSAMPLE-1 to 0 at each bit boundary.
- IDLE:
  - On an ena tick with rxs=0, go to START with sample_cnt=0.
- START:
  - At the vote point, vote=1 means false start: go to IDLE and report nothing.
  - At sample_cnt=OVERSAMPLE-1, go to DATA with bit_cnt=0.
- DATA:
  - At the vote point, shift vote into the MSB of the shift register (LSB-first assembly) and increment bit_cnt.
  - At the bit boundary after bit_cnt reaches DATA_BITS, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - At the vote point, parity_err = (XOR of data bits ^ vote) != (PARITY_MODE==2).
  - At the bit boundary, go to STOP.
- STOP:
  - Vote each of the STOP_BITS stop bits; frame_err = OR of (vote==0).
  - At the vote point of the final stop bit, the frame completes and the FSM goes to IDLE immediately, so back-to-back frames with a half-bit of stop margin are caught.
- Frame completion (registered; flags visible the cycle after the completing tick):
  - out_valid=0: load the holding register; out_valid becomes 1.
  - out_valid=1 and out_ready=1 in the same cycle: load the new word; out_valid stays 1.
  - out_valid=1 and out_ready=0: keep the old word; overrun_err pulses high for one cycle.
- Handshake:
  - Transfer occurs on a clk edge with out_valid && out_ready.
  - Transfer without a simultaneous completion clears out_valid next cycle.
  - out_data and the flags are stable while out_valid=1 and out_ready=0.
- Frames with frame_err or parity_err are still delivered; the flags travel with the word.
- ena=0 freezes the FSM, counters and vote register; the handshake and overrun logic still run every clk.
- A glitch shorter than 2 ticks inside a bit does not change the vote.

Test Plan:
- Defaults, ena every clk. Send 0x55 (7-bit, LSB first) with a valid stop bit, out_ready=1 -> one out_valid pulse with out_data=7'h55, both error flags 0, state_out back to 0.
- rx low for 3 ticks, then high -> START entered, abort at the vote point, state_out returns to 0, no out_valid.
- PARITY_MODE=1, DATA_BITS=8. Send 0xA3 with parity bit 1 -> out_parity_err=1, out_data=8'hA3. Same frame with parity bit 0 -> out_parity_err=0.
- STOP_BITS=2. Second stop bit driven 0 -> out_frame_err=1 and the word is still delivered.
- out_ready=0. Two back-to-back frames 0x12 then 0x34 -> the first frame is held (out_data=0x12, stable), overrun_err pulses once when the second completes, and out_data stays 0x12. Raising out_ready then clears out_valid the next cycle.
- Assert rst mid-DATA of frame 0x7F -> all outputs reset immediately. After release, the next clean frame 0x01 is received correctly.
